comb_ctrl: RTL and testbench

- Sequencing/configuration controller for one I/Q comb filter instance in the receive chain.
- Decodes a settings-bus register: enable, bypass and settle length.
- Runs the filter through a flush sequence (zero input, history overwritten) and a settle interval before declaring its output valid.
- Drives the filter's synchronous reset, the input-zero mux and the bypass mux. Reports status back over a readback word.

---
 rtl/comb_ctrl_pkg.sv | 25 ++
 rtl/comb_ctrl_if.sv | 10 +
 rtl/comb_ctrl_setting_reg.sv | 31 +++
 rtl/comb_ctrl.sv | 135 +++++++++++++
 tb/tb_comb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comb_ctrl_pkg.sv
// Shared definitions for the comb filter sequencer: state encoding,
// control-register bit positions and readback layout.
package comb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam logic [6:0] DEFAULT_ADDR = 7'd40;

  // Control word fields
  localparam int EN_BIT      = 0;
  localparam int BYP_BIT     = 1;
  localparam int SETTLE_LSB  = 8;
  localparam int RESTART_BIT = 31;

  // Readback word fields (settle counter field assumes SETTLE_W <= 13)
  localparam int CFG_CNT_LSB   = 16;
  localparam int CFG_VALID_BIT = 29;
  localparam int CFG_STATE_LSB = 30;

endpackage

// File: rtl/comb_ctrl_if.sv
// Settings-bus write port: the bus driver is the master, register blocks
// listening on it are slaves.
interface comb_ctrl_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, output serial_data, output serial_strobe);
  modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/comb_ctrl_setting_reg.sv
// Generic settings-bus register: captures the data word on a matching strobe
// and pulses `changed` for the cycle after each capture.
module comb_ctrl_setting_reg #(
  parameter logic [6:0]       ADDR     = 7'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe,
  input  logic [6:0]       addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out,
  output logic             changed
);

  logic hit;
  assign hit = strobe && (addr == ADDR);

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out     <= AT_RESET;
      changed <= 1'b0;
    end else begin
      changed <= hit;
      if (hit) out <= data;
    end
  end

endmodule

// File: rtl/comb_ctrl.sv
// Sequencer for one I/Q comb filter: flush the delay line, wait a settle
// interval, then flag the output valid. Bypass follows the register live.
module comb_ctrl
  import comb_ctrl_pkg::*;
#(
  parameter logic [6:0] ADDR       = DEFAULT_ADDR,
  parameter int         DELAY_LOG2 = 3,
  parameter int         SETTLE_W   = 8
) (
  input  logic         clock,
  input  logic         reset,
  comb_ctrl_if.slave   bus,
  output logic         filt_reset,
  output logic         filt_zero_in,
  output logic         bypass,
  output logic         out_valid,
  output logic [1:0]   state,
  output logic [31:0]  cfg_word
);

  localparam int FLUSH_LEN = 1 << DELAY_LOG2;
  localparam logic [SETTLE_W-1:0] FLUSH_LAST = SETTLE_W'(FLUSH_LEN - 1);
  localparam logic [31:0] WORD_AT_RESET = 32'(1) << BYP_BIT;

  logic [31:0]         word;
  logic                word_changed;
  logic                en;
  logic                byp;
  logic                restart;
  logic [SETTLE_W-1:0] settle_len;

  comb_ctrl_setting_reg #(
    .ADDR     (ADDR),
    .WIDTH    (32),
    .AT_RESET (WORD_AT_RESET)
  ) u_ctrl_reg (
    .clock   (clock),
    .reset   (reset),
    .strobe  (bus.serial_strobe),
    .addr    (bus.serial_addr),
    .data    (bus.serial_data),
    .out     (word),
    .changed (word_changed)
  );

  assign en         = word[EN_BIT];
  assign byp        = word[BYP_BIT];
  assign settle_len = word[SETTLE_LSB +: SETTLE_W];
  // Restart is only meaningful in the cycle right after it was written.
  assign restart    = word_changed && word[RESTART_BIT];

  logic unused_word;
  assign unused_word = ^{word[RESTART_BIT-1:SETTLE_LSB+SETTLE_W], word[SETTLE_LSB-1:BYP_BIT+1]};

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                filt_reset_d, filt_zero_in_d, bypass_d, out_valid_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end
      ST_SETTLE: begin
        // >= so a shortened settle_len ends SETTLE at once; saturate, never wrap
        if (cnt_q >= settle_len) begin
          state_d = ST_RUN;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end
      ST_RUN: ;
    endcase

    // Disable beats restart when both arrive in the same write.
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (restart && state_q != ST_IDLE) begin
      state_d = ST_FLUSH;
      cnt_d   = '0;
    end

    filt_reset_d   = (state_d == ST_IDLE);
    filt_zero_in_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
    bypass_d       = (state_d == ST_IDLE) || byp;
    out_valid_d    = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      filt_reset   <= 1'b1;
      filt_zero_in <= 1'b1;
      bypass       <= 1'b1;
      out_valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      filt_reset   <= filt_reset_d;
      filt_zero_in <= filt_zero_in_d;
      bypass       <= bypass_d;
      out_valid    <= out_valid_d;
    end
  end

  assign state = state_q;

  always_comb begin
    cfg_word                            = '0;
    cfg_word[EN_BIT]                    = en;
    cfg_word[BYP_BIT]                   = byp;
    cfg_word[SETTLE_LSB +: SETTLE_W]    = settle_len;
    cfg_word[CFG_CNT_LSB +: SETTLE_W]   = cnt_q;
    cfg_word[CFG_VALID_BIT]             = out_valid;
    cfg_word[CFG_STATE_LSB +: 2]        = state_q;
  end

endmodule

// File: tb/tb_comb_ctrl.sv
// Self-checking bench for comb_ctrl: directed scenarios plus a randomized
// register-write run checked against a phase/duration reference model.
module tb_comb_ctrl;

  localparam logic [6:0] ADDR = 7'd40;
  localparam int FLUSH_LEN = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        filt_reset, filt_zero_in, bypass, out_valid;
  logic [1:0]  state;
  logic [31:0] cfg_word;

  int checks   = 0;
  int failures = 0;

  comb_ctrl_if bus();

  comb_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .filt_reset   (filt_reset),
    .filt_zero_in (filt_zero_in),
    .bypass       (bypass),
    .out_valid    (out_valid),
    .state        (state),
    .cfg_word     (cfg_word)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0..3 = idle/flush/settle/run, m_spent = cycles
  // already completed in the current phase. Register writes take effect one
  // cycle after the write; restart is a one-shot seen the following cycle.
  int         m_phase, m_spent;
  bit         m_en, m_byp, m_restart, m_exp_byp;
  logic [7:0] m_len;

  task automatic model_reset();
    m_phase = 0; m_spent = 0; m_en = 0; m_byp = 1; m_len = '0;
    m_restart = 0; m_exp_byp = 1;
  endtask

  task automatic model_step(input bit wr, input logic [31:0] d);
    int nxt_phase, nxt_spent;
    nxt_phase = m_phase;
    nxt_spent = m_spent + 1;
    if (!m_en) begin
      nxt_phase = 0; nxt_spent = 0;
    end else if (m_restart && m_phase != 0) begin
      nxt_phase = 1; nxt_spent = 0;
    end else if (m_phase == 0) begin
      nxt_phase = 1; nxt_spent = 0;
    end else if (m_phase == 1 && m_spent + 1 == FLUSH_LEN) begin
      nxt_phase = 2; nxt_spent = 0;
    end else if (m_phase == 2 && m_spent + 1 >= int'(m_len) + 1) begin
      nxt_phase = 3; nxt_spent = 0;
    end
    m_exp_byp = (nxt_phase == 0) ? 1'b1 : m_byp;
    m_phase   = nxt_phase;
    m_spent   = nxt_spent;
    m_restart = wr && d[31];
    if (wr) begin
      m_en  = d[0];
      m_byp = d[1];
      m_len = d[15:8];
    end
  endtask

  function automatic logic [5:0] dut_vec();
    return {state, out_valid, bypass, filt_zero_in, filt_reset};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {2'(m_phase), m_phase == 3, m_exp_byp, m_phase <= 1, m_phase == 0};
  endfunction

  function automatic logic [31:0] exp_cfg();
    logic [31:0] v;
    v = '0;
    v[0] = m_en;
    v[1] = m_byp;
    v[15:8] = m_len;
    if (m_phase == 1 || m_phase == 2) v[23:16] = 8'(m_spent);
    v[29] = (m_phase == 3);
    v[31:30] = 2'(m_phase);
    return v;
  endfunction

  function automatic logic [31:0] cfg_mask();
    return (m_phase == 3) ? 32'hFF00_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input bit strobe, input logic [6:0] addr, input logic [31:0] data);
    bus.serial_strobe = strobe;
    bus.serial_addr   = addr;
    bus.serial_data   = data;
    @(posedge clock);
    if (!reset) model_step(strobe && addr == ADDR, data);
    #1;
    bus.serial_strobe = 1'b0;
  endtask

  task automatic write(input logic [31:0] data);
    tick(1'b1, ADDR, data);
  endtask

  task automatic idle();
    tick(1'b0, 7'd0, 32'd0);
  endtask

  task automatic test_reset();
    bus.serial_strobe = 1'b0; bus.serial_addr = '0; bus.serial_data = '0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    checks++;
    if (cfg_word !== 32'h0000_0002) begin
      failures++; $display("FAIL reset_cfg: got %h expected %h", cfg_word, 32'h0000_0002);
    end
    for (int n = 0; n < 50; n++) begin
      idle();
      checks++;
      if (dut_vec() !== 6'b00_0111) begin
        failures++; $display("FAIL reset_hold cycle %0d: got %b expected %b", n, dut_vec(), 6'b00_0111);
      end
    end
  endtask

  task automatic test_sequence();
    int n_flush = 0, n_settle = 0, run_at = -1, zero_bad = 0;
    write(32'h0000_0401);
    for (int n = 1; n <= 40 && run_at < 0; n++) begin
      idle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL seq_cycle %0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
      if (state == 2'd1) begin n_flush++; if (filt_zero_in !== 1'b1) zero_bad++; end
      if (state == 2'd2) n_settle++;
      if (state == 2'd3) run_at = n;
    end
    checks++;
    if (run_at !== 14) begin failures++; $display("FAIL seq_run_cycle: got %0d expected 14", run_at); end
    checks++;
    if (n_flush !== 8) begin failures++; $display("FAIL seq_flush_len: got %0d expected 8", n_flush); end
    checks++;
    if (n_settle !== 5) begin failures++; $display("FAIL seq_settle_len: got %0d expected 5", n_settle); end
    checks++;
    if (zero_bad !== 0) begin failures++; $display("FAIL seq_zero_in: got %0d bad cycles expected 0", zero_bad); end
    checks++;
    if ({out_valid, bypass} !== 2'b10) begin
      failures++; $display("FAIL seq_run_outputs: got %b expected 10", {out_valid, bypass});
    end
  endtask

  task automatic test_restart();
    int run_at = -1;
    write(32'h8000_0401);
    idle();
    checks++;
    if ({state, out_valid} !== 3'b010) begin
      failures++; $display("FAIL restart_drop: got %b expected 010", {state, out_valid});
    end
    for (int n = 2; n <= 40 && run_at < 0; n++) begin
      idle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL restart_cycle %0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
      if (state == 2'd3) run_at = n;
    end
    checks++;
    if (run_at !== 14) begin failures++; $display("FAIL restart_run_cycle: got %0d expected 14", run_at); end
  endtask

  task automatic test_settle_change();
    bit reached = 0;
    write(32'h8000_0401);
    for (int n = 0; n < 30 && !reached; n++) begin
      idle();
      reached = (m_phase == 2 && m_spent == 3);
    end
    checks++;
    if (!reached || cfg_word[23:16] !== 8'd3 || state !== 2'd2) begin
      failures++; $display("FAIL settle_reach: got state %0d cnt %0d expected state 2 cnt 3", state, cfg_word[23:16]);
    end
    write(32'h0000_0101);
    checks++;
    if ({state, cfg_word[23:16]} !== {2'd2, 8'd4}) begin
      failures++; $display("FAIL settle_shrink_cnt: got %h expected %h", {state, cfg_word[23:16]}, {2'd2, 8'd4});
    end
    idle();
    checks++;
    if ({state, out_valid} !== 3'b111) begin
      failures++; $display("FAIL settle_shrink_run: got %b expected 111", {state, out_valid});
    end
  endtask

  task automatic test_bypass_live();
    write(32'h0000_0003);
    idle();
    checks++;
    if ({state, out_valid, bypass} !== 4'b1111) begin
      failures++; $display("FAIL bypass_live: got %b expected 1111", {state, out_valid, bypass});
    end
    write(32'h0000_0000);
    idle();
    checks++;
    if ({state, filt_reset, out_valid} !== 4'b0010) begin
      failures++; $display("FAIL disable_idle: got %b expected 0010", {state, filt_reset, out_valid});
    end
  endtask

  task automatic test_en_wins();
    write(32'h0000_0401);
    for (int n = 0; n < 30 && state != 2'd3; n++) idle();
    checks++;
    if (state !== 2'd3) begin failures++; $display("FAIL en_wins_reach_run: got %0d expected 3", state); end
    write(32'h8000_0000);
    idle();
    checks++;
    if ({state, filt_reset, out_valid} !== 4'b0010) begin
      failures++; $display("FAIL en_wins: got %b expected 0010", {state, filt_reset, out_valid});
    end
    for (int n = 0; n < 3; n++) begin
      idle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL en_wins_hold %0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    write(32'h0000_0401);
    repeat (3) idle();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL areset_in_flush: got %0d expected 1", state); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 6'b00_0111 || cfg_word !== 32'h0000_0002) begin
      failures++; $display("FAIL areset_immediate: got %b/%h expected 000111/00000002", dut_vec(), cfg_word);
    end
    model_reset();
    #2 reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      idle();
      checks++;
      if (dut_vec() !== 6'b00_0111) begin
        failures++; $display("FAIL areset_hold %0d: got %b expected 000111", n, dut_vec());
      end
    end
    write(32'h0000_0401);
    idle();
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL areset_reenable: got %0d expected 1", state); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      bit          strobe;
      logic [6:0]  addr;
      logic [31:0] d;
      strobe = ($urandom_range(0, 7) == 0);
      addr   = ADDR;
      if ($urandom_range(0, 3) == 0) addr = 7'($urandom_range(41, 127));
      d       = $urandom;
      d[0]    = ($urandom_range(0, 7) != 0);
      d[31]   = ($urandom_range(0, 3) == 0);
      d[15:8] = 8'($urandom_range(0, 12));
      tick(strobe, addr, d);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL rand_outputs %0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
      checks++;
      if ((cfg_word & cfg_mask()) !== exp_cfg()) begin
        failures++; $display("FAIL rand_cfg %0d: got %h expected %h", n, cfg_word & cfg_mask(), exp_cfg());
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_restart();
    test_settle_change();
    test_bypass_live();
    test_en_wins();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
